// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: steps a 3-to-8 digit decoder through digits 0..last_digit with blanking gaps
module digit_scan_ctrl #(
  parameter int DIV   = 1000,
  parameter int BLANK = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [2:0]  last_digit,
  input  logic [31:0] digits,
  output logic        en,
  output logic [2:0]  sel,
  output logic [3:0]  nibble,
  output logic        frame_done
);
  localparam int MAXV = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_BLANK} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d, fd_q, fd_d;
  logic [2:0]    sel_q, sel_d, adv_sel;
  logic [3:0]    nib_q, nib_d, adv_nib;
  logic          adv_wrap;
  // next-state: advance target is computed once and shared by both advance points
  always_comb begin
    adv_wrap = sel_q >= last_digit;
    adv_sel  = adv_wrap ? 3'd0 : sel_q + 3'd1;
    adv_nib  = digits[{adv_sel, 2'b00} +: 4];
    state_d  = state_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    sel_d    = sel_q;
    nib_d    = nib_q;
    fd_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        en_d  = run;
        sel_d = 3'd0;
        cnt_d = '0;
        if (run) begin
          state_d = S_SHOW;
          nib_d   = digits[3:0];
        end
      end
      S_SHOW: begin
        if (!run) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
          sel_d   = 3'd0;
          cnt_d   = '0;
        end else if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (BLANK > 0) begin
            state_d = S_BLANK;
            en_d    = 1'b0;
          end else begin
            sel_d = adv_sel;
            nib_d = adv_nib;
            fd_d  = adv_wrap;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BLANK: begin
        if (!run) begin
          state_d = S_IDLE;
          sel_d   = 3'd0;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = S_SHOW;
          en_d    = 1'b1;
          cnt_d   = '0;
          sel_d   = adv_sel;
          nib_d   = adv_nib;
          fd_d    = adv_wrap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        sel_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase
  end
  // state and output registers; reset clears everything without waiting for clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      sel_q   <= 3'd0;
      nib_q   <= 4'd0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      nib_q   <= nib_d;
      fd_q    <= fd_d;
    end
  end
  assign en         = en_q;
  assign sel        = sel_q;
  assign nibble     = nib_q;
  assign frame_done = fd_q;
endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Sequential scan controller that sits directly upstream of the 3-to-8 one-hot decoder used for multiplexed digit/LED select.
- Produces the decoder's enable and 3-bit select, stepping through digits 0..last_digit at a programmable rate.
- Inserts a blanking gap between digits to suppress ghosting.
- Presents the 4-bit data nibble of the currently selected digit to the segment-encoding stage.

Parameters:
- DIV, 1000, clock cycles each digit is shown (en high); legal range ≥1.
- BLANK, 2, clock cycles en is held low between digits; legal range ≥0, where 0 means no gap.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  scan enable; 0 forces idle.
- last_digit  in  3  index of the highest digit scanned, 0..7.
- digits  in  32  packed nibbles; digit k is in bits [4k+3:4k].
- en  out  1  decoder enable, registered.
- sel  out  3  decoder select (digit index), registered.
- nibble  out  4  data for the digit on sel, registered.
- frame_done  out  1  one-cycle pulse at the start of each new frame.

Behaviour:
- Reset (asynchronous, active-high): en=0, sel=0, nibble=0, frame_done=0, state=IDLE, cycle counter=0. Reset may assert in any state; all outputs clear immediately, without waiting for a clock edge.
- States: IDLE, SHOW, BLANK. All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - Outputs: en=0, sel=0.
  - On the first edge with run=1: go to SHOW, sel=0, en=1, nibble=digits[3:0], counter=0.
  - frame_done does NOT pulse on this first entry.
- SHOW:
  - en=1; counter increments each cycle.
  - At the edge where counter==DIV-1: counter clears, then one of two actions:
    - BLANK>0: go to BLANK, en=0, sel and nibble held.
    - BLANK==0: advance directly to the next digit in SHOW; en stays 1.
- BLANK:
  - en=0 for exactly BLANK cycles.
  - At the edge where counter==BLANK-1: advance to the next digit in SHOW, en=1.
- Advance rule:
  - If sel ≥ last_digit: next sel=0, and frame_done=1 for that one cycle.
  - Otherwise: next sel=sel+1.
  - nibble is loaded with digits[4·next_sel+3 : 4·next_sel] on the same edge. nibble is stable for the entire SHOW window; digits changes mid-window take effect at the next advance.
- last_digit is sampled only at advance. If it is lowered below the current sel mid-frame, the ≥ compare wraps to 0 at the next advance; sel never runs to 7 unnecessarily.
- last_digit=0: sel stays 0, and frame_done pulses once per (DIV+BLANK) cycles.
- run=0 sampled in SHOW or BLANK: next edge goes to IDLE, en=0, sel=0, counter=0, no frame_done pulse. nibble holds its last value.
- Timing:
  - Frame period = (last_digit+1)·(DIV+BLANK) cycles.
  - en duty cycle = DIV/(DIV+BLANK).
- Counter width: enough to hold max(DIV, BLANK)-1. No overflow is possible within the legal ranges.
- en is never high while sel changes: with BLANK>0, sel changes only on the BLANK→SHOW edge, so en is low in the cycle before every sel change.

Test Plan (DIV=4, BLANK=2 unless noted):
- Basic scan:
  - Setup: reset, digits=32'h76543210, last_digit=3, run=1.
  - Required en pattern: 1111 00 repeating.
  - Required sel sequence: 0,1,2,3,0…, each held 6 cycles.
  - Required nibble: equals sel in each window.
  - Required frame_done: pulses once every 24 cycles, coincident with sel returning to 0. No pulse on the first entry from IDLE.
- No blanking:
  - Setup: BLANK=0, last_digit=1.
  - Required: en stays 1 continuously; sel toggles every 4 cycles; frame_done every 8 cycles.
- Single digit and shrink:
  - Setup: last_digit=0.
  - Required: sel stuck at 0; frame_done every 6 cycles.
  - Then, while sel=5 with last_digit=7, set last_digit=2.
  - Required: next advance gives sel=0 with a frame_done pulse.
- Stop/restart:
  - Stimulus: drop run during the SHOW window of digit 2.
  - Required: next cycle en=0, sel=0, no frame_done.
  - Then reassert run.
  - Required: scan restarts at digit 0 with a full 4-cycle window.
- Data timing:
  - Stimulus: change digits[7:4] from 1 to A mid-window of digit 1.
  - Required: nibble stays 1 until the next time digit 1 is selected, then shows A.
- Async reset:
  - Stimulus: assert rst mid-cycle during BLANK, between clock edges.
  - Required: en, sel, nibble and frame_done clear to 0 before the next clock edge.
  - After release with run=1: first edge enters SHOW at digit 0.
